sdram_avm_pattern_tester: RTL and testbench

Avalon-MM master that sits directly upstream of the SDRAM controller's slave port inside the board system, next to the Nios data master.
- On a start pulse it writes an address-derived pattern over a word range, then reads the range back with pipelined reads.
- It compares each returned word and reports pass/fail, an error count and the first failing address.
- Used for board bring-up and soak testing of the 16-bit SDRAM.

---
 rtl/sdram_test_pkg.sv | 21 ++
 rtl/sdram_avm_pattern_tester_if.sv | 26 ++
 rtl/sdram_test_pending_ctr.sv | 31 +++
 rtl/sdram_avm_pattern_tester.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_avm_pattern_tester.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_test_pkg.sv
// Shared types and the address-derived test pattern for the SDRAM pattern tester.
package sdram_test_pkg;

    localparam int DATA_W     = 16;
    localparam int PAT_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Folding the upper address bits in keeps the pattern distinct across 64K-word pages.
    function automatic logic [DATA_W-1:0] pat(input logic [PAT_ADDR_W-1:0] addr,
                                              input logic [DATA_W-1:0]     seed);
        return seed ^ addr[15:0] ^ addr[31:16];
    endfunction

endpackage

// File: rtl/sdram_avm_pattern_tester_if.sv
// Avalon-MM word bus between the pattern tester (master) and the SDRAM controller (slave).
interface sdram_avm_if #(
    parameter int ADDR_W = 25
);
    import sdram_test_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [1:0]        byteenable;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/sdram_test_pending_ctr.sv
// Outstanding-read counter; an accept and a return in the same cycle cancel out.
module sdram_test_pending_ctr #(
    parameter int MAX_PENDING = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0] count;

    // A return with nothing outstanding is dropped rather than wrapping the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign full  = (count == CNT_W'(MAX_PENDING));
    assign empty = (count == '0);

endmodule

// File: rtl/sdram_avm_pattern_tester.sv
// Avalon-MM SDRAM pattern tester: writes pat(addr) over 0..last_addr, reads back pipelined, counts mismatches.
// Optional SDRAM_TEST_LOOP_EN: repeat passes with seed+1 until start is pulsed again; adds pass_count.
module sdram_avm_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int MAX_PENDING = 7
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic [ADDR_W-1:0] last_addr,
    sdram_avm_if.master       avm,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
`ifdef SDRAM_TEST_LOOP_EN
    ,
    output logic [15:0]       pass_count
`endif
);

    state_t            state;
    state_t            next_state;
    logic [15:0]       seed_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ret_addr;
    logic              rd_armed;
    logic              pend_full;
    logic              pend_empty;
    logic              wr_accept;
    logic              rd_accept;
    logic              ret_valid;
    logic              ret_mismatch;
    logic              loop_continue;

    assign wr_accept    = avm.write && !avm.waitrequest;
    assign rd_accept    = avm.read && !avm.waitrequest;
    assign ret_valid    = avm.readdatavalid && (state == READ || state == DRAIN);
    assign ret_mismatch = ret_valid && (avm.readdata != pat(PAT_ADDR_W'(ret_addr), seed_q));

    sdram_test_pending_ctr #(
        .MAX_PENDING(MAX_PENDING)
    ) u_pending (
        .clk  (clk_clk),
        .rst_n(reset_reset_n),
        .inc  (rd_accept),
        .dec  (ret_valid),
        .full (pend_full),
        .empty(pend_empty)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = WRITE;
            WRITE:   if (wr_accept && wr_addr == last_q) next_state = READ;
            READ:    if (rd_accept && rd_addr == last_q) next_state = DRAIN;
            DRAIN:   if (pend_empty) next_state = DONE;
            DONE:    next_state = loop_continue ? WRITE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // rd_armed holds off the first read one cycle so writes and reads never touch back to back.
    always_comb begin
        avm.address    = '0;
        avm.read       = 1'b0;
        avm.write      = 1'b0;
        avm.writedata  = '0;
        avm.byteenable = 2'b11;
        unique case (state)
            WRITE: begin
                avm.write     = 1'b1;
                avm.address   = wr_addr;
                avm.writedata = pat(PAT_ADDR_W'(wr_addr), seed_q);
            end
            READ: begin
                avm.read    = rd_armed && !pend_full;
                avm.address = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            seed_q         <= '0;
            last_q         <= '0;
            wr_addr        <= '0;
            rd_addr        <= '0;
            ret_addr       <= '0;
            rd_armed       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        seed_q         <= seed;
                        last_q         <= last_addr;
                        wr_addr        <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_accept) begin
                        if (wr_addr == last_q) begin
                            rd_addr  <= '0;
                            ret_addr <= '0;
                            rd_armed <= 1'b0;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                READ: begin
                    rd_armed <= 1'b1;
                    if (rd_accept && rd_addr != last_q) begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DONE: begin
                    if (loop_continue) begin
                        seed_q  <= seed_q + 16'd1;
                        wr_addr <= '0;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == 16'd0);
                    end
                end
                default: ;
            endcase

            if (ret_valid) begin
                ret_addr <= ret_addr + 1'b1;
                if (ret_mismatch) begin
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                    if (err_count == 16'd0) begin
                        first_err_addr <= ret_addr;
                    end
                end
            end
        end
    end

`ifdef SDRAM_TEST_LOOP_EN
    logic stop_req;
    logic pass_err;

    assign loop_continue = !(stop_req || start);

    // A start seen while busy is remembered and honoured at the next pass boundary.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stop_req   <= 1'b0;
            pass_err   <= 1'b0;
            pass_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                stop_req   <= 1'b0;
                pass_err   <= 1'b0;
                pass_count <= '0;
            end else if (state == DONE) begin
                stop_req <= 1'b0;
                pass_err <= 1'b0;
                if (!pass_err && pass_count != 16'hFFFF) begin
                    pass_count <= pass_count + 16'd1;
                end
            end else if (busy && start) begin
                stop_req <= 1'b1;
            end
            if (ret_mismatch) begin
                pass_err <= 1'b1;
            end
        end
    end
`else
    assign loop_continue = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_avm_pattern_tester.sv
// Directed bench for sdram_avm_pattern_tester with a small Avalon-MM SDRAM slave model.
module tb_sdram_avm_pattern_tester;

    localparam int ADDR_W = 25;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       seed  = 16'h0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
`ifdef SDRAM_TEST_LOOP_EN
    logic [15:0]       pass_count;
`endif

    int checks   = 0;
    int failures = 0;

    sdram_avm_if #(.ADDR_W(ADDR_W)) avm ();

    sdram_avm_pattern_tester #(
        .ADDR_W     (ADDR_W),
        .MAX_PENDING(7)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .start         (start),
        .seed          (seed),
        .last_addr     (last_addr),
        .avm           (avm),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
`ifdef SDRAM_TEST_LOOP_EN
        ,
        .pass_count    (pass_count)
`endif
    );

    always #5 clk = ~clk;

    // Slave model state
    logic [15:0]       mem [0:255];
    int unsigned       cyc = 0;
    int unsigned       lat = 3;
    bit                rand_wait = 1'b0;
    bit                flip5 = 1'b0;
    bit                flip_all = 1'b0;
    logic [15:0]       q_data [$];
    int unsigned       q_due [$];
    int                model_out = 0;
    int                max_out = 0;
    int                writes = 0;
    int                reads = 0;
    int                wr_seq_err = 0;
    int                wr_data_err = 0;
    int                rd_seq_err = 0;
    int                gap_err = 0;
    int                hold_err = 0;
    int                proto_err = 0;
    logic [ADDR_W-1:0] exp_wr = '0;
    logic [ADDR_W-1:0] exp_rd = '0;
    logic [ADDR_W-1:0] m_last = '0;
    logic [15:0]       m_seed = 16'h0;
    bit                prev_write = 1'b0;
    bit                prev_stall = 1'b0;
    logic [1:0]        prev_rw = 2'b00;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [15:0]       prev_wdata = 16'h0;

    function automatic logic [15:0] model_pat(input logic [15:0] s, input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return s ^ w[15:0] ^ w[31:16];
    endfunction

    // Slave drives its inputs and observes the master at the falling edge, away from the DUT's edge.
    always @(negedge clk) begin
        logic [15:0] d;
        cyc++;
        avm.waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            d = q_data.pop_front();
            void'(q_due.pop_front());
            avm.readdatavalid = 1'b1;
            avm.readdata      = flip_all ? ~d : d;
            model_out--;
        end else begin
            avm.readdatavalid = 1'b0;
            avm.readdata      = 16'h0;
        end
        if (rst_n) begin
            if (prev_stall && ({avm.read, avm.write} !== prev_rw || avm.address !== prev_addr ||
                               avm.writedata !== prev_wdata)) hold_err++;
            if (avm.read && prev_write) gap_err++;
            if ((avm.read && avm.write) || ((avm.read || avm.write) && avm.byteenable !== 2'b11)) proto_err++;
            if (avm.write && !avm.waitrequest) begin
                if (avm.address !== exp_wr) wr_seq_err++;
                if (avm.writedata !== model_pat(m_seed, avm.address)) wr_data_err++;
                mem[avm.address[7:0]] = avm.writedata;
                writes++;
                exp_wr = (exp_wr == m_last) ? '0 : exp_wr + 1'b1;
            end
            if (avm.read && !avm.waitrequest) begin
                if (avm.address !== exp_rd) rd_seq_err++;
                d = mem[avm.address[7:0]];
                if (flip5 && avm.address == 5) d = d ^ 16'h0001;
                q_data.push_back(d);
                q_due.push_back(cyc + lat);
                reads++;
                model_out++;
                if (model_out > max_out) max_out = model_out;
                if (exp_rd == m_last) begin
                    exp_rd = '0;
                    m_seed = m_seed + 16'd1;
                end else begin
                    exp_rd = exp_rd + 1'b1;
                end
            end
        end
        prev_write = rst_n && avm.write;
        prev_stall = rst_n && (avm.read || avm.write) && avm.waitrequest;
        prev_rw    = {avm.read, avm.write};
        prev_addr  = avm.address;
        prev_wdata = avm.writedata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input logic [15:0] s, input logic [ADDR_W-1:0] la);
        m_seed = s; m_last = la; exp_wr = '0; exp_rd = '0;
        writes = 0; reads = 0; max_out = 0;
        wr_seq_err = 0; wr_data_err = 0; rd_seq_err = 0; gap_err = 0; hold_err = 0; proto_err = 0;
        seed = s; last_addr = la; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("[TB] FAIL reset_pass got=%b exp=0", pass); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("[TB] FAIL reset_err_count got=%h exp=0", err_count); end
        checks++; if (first_err_addr !== '0) begin failures++; $display("[TB] FAIL reset_first_err got=%h exp=0", first_err_addr); end
        checks++; if (avm.read !== 1'b0 || avm.write !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b%b exp=00", avm.read, avm.write); end
        checks++; if (avm.address !== '0 || avm.writedata !== 16'h0) begin failures++; $display("[TB] FAIL reset_bus addr=%h data=%h exp=0", avm.address, avm.writedata); end
        checks++; if (avm.byteenable !== 2'b11) begin failures++; $display("[TB] FAIL reset_byteenable got=%b exp=11", avm.byteenable); end
        rst_n = 1'b1;
        tick();
    endtask

`ifndef SDRAM_TEST_LOOP_EN
    task automatic test_basic();
        bit ok;
        lat = 3; rand_wait = 1'b0; flip5 = 1'b0;
        start_test(16'hA5A5, 15);
        checks++; if (avm.write !== 1'b1 || avm.address !== '0) begin failures++; $display("[TB] FAIL basic_first_write write=%b addr=%h exp=1/0", avm.write, avm.address); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy got=%b exp=1", busy); end
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_timeout done=%b exp=1", done); end
        checks++; if (pass !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_pass pass=%b busy=%b exp=1/0", pass, busy); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("[TB] FAIL basic_err_count got=%h exp=0", err_count); end
        checks++; if (writes != 16 || reads != 16) begin failures++; $display("[TB] FAIL basic_counts writes=%0d reads=%0d exp=16/16", writes, reads); end
        checks++; if (mem[3] !== 16'hA5A6) begin failures++; $display("[TB] FAIL basic_word3 got=%h exp=a5a6", mem[3]); end
        checks++; if (wr_seq_err + wr_data_err + rd_seq_err != 0) begin failures++; $display("[TB] FAIL basic_sequence wr_seq=%0d wr_data=%0d rd_seq=%0d exp=0", wr_seq_err, wr_data_err, rd_seq_err); end
        checks++; if (gap_err + proto_err != 0) begin failures++; $display("[TB] FAIL basic_protocol gap=%0d proto=%0d exp=0", gap_err, proto_err); end
        repeat (3) tick();
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin failures++; $display("[TB] FAIL basic_hold done=%b pass=%b exp=1/1", done, pass); end
    endtask

    task automatic test_error();
        bit ok;
        lat = 10; flip5 = 1'b1;
        start_test(16'h1234, 31);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL error_done_clear got=%b exp=0", done); end
        wait_done(300, ok);
        flip5 = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL error_timeout done=%b exp=1", done); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("[TB] FAIL error_count got=%0d exp=1", err_count); end
        checks++; if (first_err_addr !== 25'd5) begin failures++; $display("[TB] FAIL error_first_addr got=%0d exp=5", first_err_addr); end
        checks++; if (pass !== 1'b0) begin failures++; $display("[TB] FAIL error_pass got=%b exp=0", pass); end
        checks++; if (max_out != 7) begin failures++; $display("[TB] FAIL error_max_pending got=%0d exp=7", max_out); end
        checks++; if (reads != 32 || rd_seq_err != 0) begin failures++; $display("[TB] FAIL error_reads reads=%0d seq=%0d exp=32/0", reads, rd_seq_err); end
    endtask

    task automatic test_stall();
        bit ok;
        lat = 8; rand_wait = 1'b1;
        start_test(16'h0F0F, 63);
        wait_done(3000, ok);
        rand_wait = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL stall_timeout done=%b exp=1", done); end
        checks++; if (max_out > 7) begin failures++; $display("[TB] FAIL stall_max_pending got=%0d exp<=7", max_out); end
        checks++; if (writes != 64 || reads != 64) begin failures++; $display("[TB] FAIL stall_counts writes=%0d reads=%0d exp=64/64", writes, reads); end
        checks++; if (wr_seq_err + rd_seq_err + wr_data_err != 0) begin failures++; $display("[TB] FAIL stall_sequence wr_seq=%0d rd_seq=%0d wr_data=%0d exp=0", wr_seq_err, rd_seq_err, wr_data_err); end
        checks++; if (hold_err != 0) begin failures++; $display("[TB] FAIL stall_hold got=%0d exp=0", hold_err); end
        checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin failures++; $display("[TB] FAIL stall_pass pass=%b err=%0d exp=1/0", pass, err_count); end
    endtask

    task automatic test_single();
        bit ok;
        lat = 3;
        start_test(16'hBEEF, 0);
        checks++; if (done !== 1'b0 || avm.write !== 1'b1) begin failures++; $display("[TB] FAIL single_start done=%b write=%b exp=0/1", done, avm.write); end
        repeat (2) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", busy); end
        seed = 16'h0000; last_addr = 25'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL single_timeout done=%b exp=1", done); end
        checks++; if (writes != 1 || reads != 1) begin failures++; $display("[TB] FAIL single_counts writes=%0d reads=%0d exp=1/1", writes, reads); end
        checks++; if (mem[0] !== 16'hBEEF || wr_data_err != 0) begin failures++; $display("[TB] FAIL single_word0 got=%h exp=beef", mem[0]); end
        checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin failures++; $display("[TB] FAIL single_pass pass=%b err=%0d exp=1/0", pass, err_count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        lat = 8;
        start_test(16'h5A5A, 63);
        n = 0;
        while (model_out != 4 && n < 500) begin
            tick();
            n++;
        end
        checks++; if (model_out != 4) begin failures++; $display("[TB] FAIL rmid_reach_outstanding got=%0d exp=4", model_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin failures++; $display("[TB] FAIL rmid_reset_status busy=%b done=%b pass=%b exp=000", busy, done, pass); end
        checks++; if (avm.read !== 1'b0 || avm.write !== 1'b0 || avm.address !== '0) begin failures++; $display("[TB] FAIL rmid_reset_bus rw=%b%b addr=%h exp=00/0", avm.read, avm.write, avm.address); end
        flip_all = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        while (q_due.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        flip_all = 1'b0;
        checks++; if (q_due.size() != 0) begin failures++; $display("[TB] FAIL rmid_stale_drain left=%0d exp=0", q_due.size()); end
        checks++; if (err_count !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rmid_stale_ignored err=%0d busy=%b done=%b exp=0/0/0", err_count, busy, done); end
        start_test(16'h0001, 7);
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rmid_timeout done=%b exp=1", done); end
        checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin failures++; $display("[TB] FAIL rmid_pass pass=%b err=%0d exp=1/0", pass, err_count); end
        checks++; if (writes != 8 || reads != 8 || rd_seq_err != 0) begin failures++; $display("[TB] FAIL rmid_counts writes=%0d reads=%0d seq=%0d exp=8/8/0", writes, reads, rd_seq_err); end
    endtask
`else
    task automatic test_loop();
        bit ok;
        int n;
        lat = 3;
        start_test(16'hA5A6, 7);
        n = 0;
        while (writes < 17 && n < 500) begin
            tick();
            n++;
        end
        checks++; if (writes < 17) begin failures++; $display("[TB] FAIL loop_third_pass writes=%0d exp>=17", writes); end
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL loop_busy busy=%b done=%b exp=1/0", busy, done); end
        seed = 16'h0000; last_addr = '0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL loop_timeout done=%b exp=1", done); end
        checks++; if (pass_count !== 16'd3) begin failures++; $display("[TB] FAIL loop_pass_count got=%0d exp=3", pass_count); end
        checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin failures++; $display("[TB] FAIL loop_pass pass=%b err=%0d exp=1/0", pass, err_count); end
        checks++; if (writes != 24 || reads != 24) begin failures++; $display("[TB] FAIL loop_counts writes=%0d reads=%0d exp=24/24", writes, reads); end
        checks++; if (mem[0] !== 16'hA5A8 || mem[3] !== 16'hA5AB) begin failures++; $display("[TB] FAIL loop_seed word0=%h word3=%h exp=a5a8/a5ab", mem[0], mem[3]); end
        checks++; if (wr_data_err + wr_seq_err != 0) begin failures++; $display("[TB] FAIL loop_write_data data=%0d seq=%0d exp=0", wr_data_err, wr_seq_err); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SDRAM_TEST_LOOP_EN
        test_loop();
`else
        test_basic();
        test_error();
        test_stall();
        test_single();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
